// File: rtl/csr_port_arbiter_pkg.sv
// Shared types for the CSR port arbiter.
//
// Contents:
//   CSR_Code                 CSR operation code carried with every access.
//   CSR_NumberPath           12-bit CSR address.
//   DataPath                 32-bit CSR data word.
//   CSR_PortArbState         arbiter FSM states (IDLE, RESP).
//   CSR_ArbStarveCountPath   starvation counter width.
//   CSR_ARB_STARVE_LIMIT_MAX largest usable starvation limit.
package csr_port_arbiter_pkg;

  typedef logic [11:0] CSR_NumberPath;
  typedef logic [31:0] DataPath;

  typedef enum logic [1:0] {
    CSR_UNKNOWN,
    CSR_WRITE,
    CSR_SET,
    CSR_CLEAR
  } CSR_Code;

  typedef enum logic [0:0] {
    IDLE,
    RESP
  } CSR_PortArbState;

  typedef logic [3:0] CSR_ArbStarveCountPath;

  localparam int unsigned CSR_ARB_STARVE_LIMIT_MAX = 15;

endpackage

// File: rtl/csr_arb_starve_counter.sv
// Saturating starvation counter for the CSR port arbiter.
//
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   inc       count one refused debug-request cycle
//   clear     return to zero (wins over everything else)
//   hold      freeze the count (wins over inc)
//   count     current count
//   atLimit   count has reached LIMIT
module csr_arb_starve_counter
  import csr_port_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic                  clear,
  input  logic                  hold,
  output CSR_ArbStarveCountPath count,
  output logic                  atLimit
);

  localparam CSR_ArbStarveCountPath LimitCnt = CSR_ArbStarveCountPath'(LIMIT);

  CSR_ArbStarveCountPath count_q, count_d;

  assign atLimit = (count_q == LimitCnt);
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (!hold && inc && !atLimit) begin
      count_d = count_q + CSR_ArbStarveCountPath'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/csr_port_arbiter.sv
// Shares the single CSR unit access port between the pipeline and a
// debug/host requester. Pipeline accesses pass straight through; debug
// accesses take idle cycles, and never a cycle in which a trap or interrupt
// is taken. The debug read data is registered and held until the debug side
// accepts it.
//
// Build option: CSR_PORT_ARBITER_STARVATION_GUARD_EN
//   defined     a debug request refused STARVE_LIMIT consecutive cycles is
//               forced onto the port by stalling the pipeline.
//   undefined   strict pipeline priority; pipeStall is tied low.
//
// Ports:
//   clk, rst                                   clock, async active-high reset
//   pipeReq/pipeWE/pipeNumber/pipeCode/pipeWriteIn  pipeline access
//   pipeReadOut, pipeStall                     pipeline read data, stall
//   dbgReq/dbgWE/dbgNumber/dbgCode/dbgWriteIn  debug access request
//   dbgGnt                                     debug access performed now
//   dbgRespValid/dbgRespReady/dbgReadOut       registered debug response
//   triggerExcpt, triggerInterrupt             trap being taken this cycle
//   csrWE/csrNumber/csrCode/csrWriteIn         to the CSR unit
//   csrReadOut                                 from the CSR unit
module csr_port_arbiter
  import csr_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipeReq,
  input  logic          pipeWE,
  input  CSR_NumberPath pipeNumber,
  input  CSR_Code       pipeCode,
  input  DataPath       pipeWriteIn,
  output DataPath       pipeReadOut,
  output logic          pipeStall,
  input  logic          dbgReq,
  input  logic          dbgWE,
  input  CSR_NumberPath dbgNumber,
  input  CSR_Code       dbgCode,
  input  DataPath       dbgWriteIn,
  output logic          dbgGnt,
  output logic          dbgRespValid,
  input  logic          dbgRespReady,
  output DataPath       dbgReadOut,
  input  logic          triggerExcpt,
  input  logic          triggerInterrupt,
  output logic          csrWE,
  output CSR_NumberPath csrNumber,
  output CSR_Code       csrCode,
  output DataPath       csrWriteIn,
  input  DataPath       csrReadOut
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > CSR_ARB_STARVE_LIMIT_MAX) begin : gen_bad_limit
    $error("csr_port_arbiter: STARVE_LIMIT out of range 1..15");
  end

  CSR_PortArbState state_q, state_d;
  DataPath         dbg_read_q;
  logic            trap;
  logic            forced;
  logic            grant;

  assign trap = triggerExcpt | triggerInterrupt;

`ifdef CSR_PORT_ARBITER_STARVATION_GUARD_EN
  logic                  starve_inc;
  logic                  starve_hold;
  CSR_ArbStarveCountPath starve_cnt;

  // Every refused IDLE request cycle counts, trap cycles included, so a
  // forced grant is pending as soon as the trap cycle is over.
  assign starve_inc  = (state_q == IDLE) && dbgReq && !grant;
  assign starve_hold = (state_q == RESP);

  csr_arb_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_counter (
    .clk     (clk),
    .rst     (rst),
    .inc     (starve_inc),
    .clear   (grant),
    .hold    (starve_hold),
    .count   (starve_cnt),
    .atLimit (forced)
  );

  // A forced grant takes the port away from a live pipeline access.
  assign pipeStall = grant && pipeReq;
`else
  assign forced    = 1'b0;
  assign pipeStall = 1'b0;
`endif

  assign grant = (state_q == IDLE) && dbgReq && !trap && (!pipeReq || forced);

  assign dbgGnt       = grant;
  assign dbgRespValid = (state_q == RESP);
  assign dbgReadOut   = dbg_read_q;
  assign pipeReadOut  = csrReadOut;

  // Port mux: the debug fields only when granted, pipeline otherwise.
  always_comb begin
    csrWE      = pipeReq && pipeWE;
    csrNumber  = pipeNumber;
    csrCode    = pipeCode;
    csrWriteIn = pipeWriteIn;
    if (grant) begin
      csrWE      = dbgWE;
      csrNumber  = dbgNumber;
      csrCode    = dbgCode;
      csrWriteIn = dbgWriteIn;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (grant) state_d = RESP;
      RESP: if (dbgRespReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_read_q <= '0;
    end else if (grant) begin
      dbg_read_q <= csrReadOut;
    end
  end

endmodule

// File: tb/tb_csr_port_arbiter.sv
module tb_csr_port_arbiter;
  import csr_port_arbiter_pkg::*;

  localparam int unsigned StarveLimit = 4;

`ifdef CSR_PORT_ARBITER_STARVATION_GUARD_EN
  localparam bit GuardEn = 1'b1;
`else
  localparam bit GuardEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          pipeReq, pipeWE;
  CSR_NumberPath pipeNumber;
  CSR_Code       pipeCode;
  DataPath       pipeWriteIn, pipeReadOut;
  logic          pipeStall;
  logic          dbgReq, dbgWE;
  CSR_NumberPath dbgNumber;
  CSR_Code       dbgCode;
  DataPath       dbgWriteIn;
  logic          dbgGnt, dbgRespValid, dbgRespReady;
  DataPath       dbgReadOut;
  logic          triggerExcpt, triggerInterrupt;
  logic          csrWE;
  CSR_NumberPath csrNumber;
  CSR_Code       csrCode;
  DataPath       csrWriteIn, csrReadOut;

  int checks = 0;
  int errors = 0;

  // Minimal CSR unit: plain register file, combinational read.
  DataPath csr_mem [4096];
  assign csrReadOut = csr_mem[csrNumber];
  always @(posedge clk) if (csrWE) csr_mem[csrNumber] <= csrWriteIn;

  always #5 clk = ~clk;

  csr_port_arbiter #(
    .STARVE_LIMIT (StarveLimit)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .pipeReq          (pipeReq),
    .pipeWE           (pipeWE),
    .pipeNumber       (pipeNumber),
    .pipeCode         (pipeCode),
    .pipeWriteIn      (pipeWriteIn),
    .pipeReadOut      (pipeReadOut),
    .pipeStall        (pipeStall),
    .dbgReq           (dbgReq),
    .dbgWE            (dbgWE),
    .dbgNumber        (dbgNumber),
    .dbgCode          (dbgCode),
    .dbgWriteIn       (dbgWriteIn),
    .dbgGnt           (dbgGnt),
    .dbgRespValid     (dbgRespValid),
    .dbgRespReady     (dbgRespReady),
    .dbgReadOut       (dbgReadOut),
    .triggerExcpt     (triggerExcpt),
    .triggerInterrupt (triggerInterrupt),
    .csrWE            (csrWE),
    .csrNumber        (csrNumber),
    .csrCode          (csrCode),
    .csrWriteIn       (csrWriteIn),
    .csrReadOut       (csrReadOut)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change just after the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) csr_mem[i] = '0;
    csr_mem[12'h300] = 32'h1888;

    rst = 1'b1;
    pipeReq = 0; pipeWE = 0; pipeNumber = '0; pipeCode = CSR_UNKNOWN; pipeWriteIn = '0;
    dbgReq = 0; dbgWE = 0; dbgNumber = '0; dbgCode = CSR_UNKNOWN; dbgWriteIn = '0;
    dbgRespReady = 0; triggerExcpt = 0; triggerInterrupt = 0;

    // Reset state
    #2;
    check_eq("rst_gnt", dbgGnt, 0);
    check_eq("rst_valid", dbgRespValid, 0);
    check_eq("rst_rdata", dbgReadOut, 0);
    check_eq("rst_stall", pipeStall, 0);
    check_eq("rst_we", csrWE, 0);
    step();
    rst = 1'b0;

    // Debug write to mscratch in an idle cycle
    dbgReq = 1; dbgWE = 1; dbgNumber = 12'h340; dbgCode = CSR_WRITE; dbgWriteIn = 32'hA5A5;
    #1;
    check_eq("w_gnt", dbgGnt, 1);
    check_eq("w_we", csrWE, 1);
    check_eq("w_num", csrNumber, 32'h340);
    check_eq("w_data", csrWriteIn, 32'hA5A5);
    check_eq("w_code", csrCode, CSR_WRITE);
    check_eq("w_stall", pipeStall, 0);
    step();
    dbgReq = 0; dbgWE = 0;
    #1;
    check_eq("w_valid", dbgRespValid, 1);
    check_eq("w_mscratch", csr_mem[12'h340], 32'hA5A5);
    check_eq("w_rdata_old", dbgReadOut, 0);
    dbgRespReady = 1;
    step();
    dbgRespReady = 0;
    #1;
    check_eq("w_valid_drop", dbgRespValid, 0);

    // Pipeline busy every cycle with a pending debug read of 0x300
    pipeReq = 1; pipeWE = 0; pipeNumber = 12'h340; pipeCode = CSR_SET;
    dbgReq = 1; dbgWE = 0; dbgNumber = 12'h300; dbgCode = CSR_SET;
    if (GuardEn) begin
      for (int i = 0; i < int'(StarveLimit); i++) begin
        #1;
        check_eq("starve_gnt", dbgGnt, 0);
        check_eq("starve_stall", pipeStall, 0);
        step();
      end
      #1;
      check_eq("forced_gnt", dbgGnt, 1);
      check_eq("forced_stall", pipeStall, 1);
      check_eq("forced_num", csrNumber, 32'h300);
    end else begin
      for (int i = 0; i < 20; i++) begin
        #1;
        check_eq("prio_gnt", dbgGnt, 0);
        check_eq("prio_stall", pipeStall, 0);
        step();
      end
      #1;
      check_eq("prio_pipe_num", csrNumber, 32'h340);
      check_eq("prio_pipe_rd", pipeReadOut, 32'hA5A5);
      pipeReq = 0;
      #1;
      check_eq("late_gnt", dbgGnt, 1);
      check_eq("late_num", csrNumber, 32'h300);
      check_eq("late_we", csrWE, 0);
    end
    step();

    // Response held while not accepted; pipeline keeps the port
    pipeReq = 1; pipeWE = 1; pipeNumber = 12'h340; pipeCode = CSR_WRITE; pipeWriteIn = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("hold_valid", dbgRespValid, 1);
      check_eq("hold_rdata", dbgReadOut, 32'h1888);
      check_eq("hold_gnt", dbgGnt, 0);
      check_eq("hold_we", csrWE, 1);
      check_eq("hold_num", csrNumber, 32'h340);
      step();
    end
    check_eq("hold_pipe_wr", csr_mem[12'h340], 32'h1234);
    dbgRespReady = 1; dbgReq = 0; pipeReq = 0; pipeWE = 0;
    step();
    dbgRespReady = 0;
    #1;
    check_eq("hold_done", dbgRespValid, 0);

    // Trap cycles block the debug grant (forced too, when the guard is on)
    dbgReq = 1; dbgWE = 1; dbgNumber = 12'h340; dbgCode = CSR_WRITE; dbgWriteIn = 32'h5A5A;
    pipeReq = GuardEn; pipeNumber = 12'h300;
    if (GuardEn) begin
      for (int i = 0; i < int'(StarveLimit); i++) begin
        #1;
        check_eq("trap_pre_gnt", dbgGnt, 0);
        step();
      end
    end
    triggerExcpt = 1;
    #1;
    check_eq("excpt_gnt", dbgGnt, 0);
    check_eq("excpt_stall", pipeStall, 0);
    check_eq("excpt_we", csrWE, 0);
    step();
    triggerExcpt = 0; triggerInterrupt = 1;
    #1;
    check_eq("irq_gnt", dbgGnt, 0);
    check_eq("irq_we", csrWE, 0);
    step();
    triggerInterrupt = 0;
    #1;
    check_eq("trap_after_gnt", dbgGnt, 1);
    check_eq("trap_after_stall", pipeStall, GuardEn);
    check_eq("trap_after_we", csrWE, 1);
    step();
    dbgReq = 0; dbgWE = 0; pipeReq = 0;
    #1;
    check_eq("trap_rdata", dbgReadOut, 32'h1234);
    check_eq("trap_wr", csr_mem[12'h340], 32'h5A5A);
    dbgRespReady = 1;
    step();
    dbgRespReady = 0;

    // Reset while a response is pending
    dbgReq = 1; dbgNumber = 12'h340; dbgCode = CSR_SET;
    #1;
    check_eq("r_gnt", dbgGnt, 1);
    step();
    dbgReq = 0;
    #1;
    check_eq("r_valid", dbgRespValid, 1);
    check_eq("r_rdata", dbgReadOut, 32'h5A5A);
    rst = 1;
    #1;
    check_eq("r_async_valid", dbgRespValid, 0);
    check_eq("r_async_rdata", dbgReadOut, 0);
    step();
    rst = 0;
    #1;
    check_eq("r_post_valid", dbgRespValid, 0);
    dbgReq = 1;
    #1;
    check_eq("r_post_gnt", dbgGnt, 1);
    step();
    dbgReq = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csr_port_arbiter.md
# csr_port_arbiter

Shares the single CSR access port of the CSR unit between the pipeline (memory execution stage) and a debug/host requester. Pipeline accesses pass through in the same cycle. Debug accesses are granted in idle cycles, or forcibly after a bounded wait by stalling the pipeline. Debug writes are never issued in a cycle where a trap or interrupt is being taken.

## Interface
Parameters:
- STARVE_LIMIT, 4: number of consecutive refused debug-request cycles before the debug requester is forced onto the port (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- pipeReq  in  1  pipeline CSR access this cycle
- pipeWE / pipeNumber / pipeCode / pipeWriteIn  in  1 / 12 / CSR_Code / 32  pipeline access fields
- pipeReadOut  out  32  read data returned to the pipeline (combinational)
- pipeStall  out  1  pipeline must hold its CSR instruction this cycle
- dbgReq  in  1  debug access request (level; held until granted)
- dbgWE / dbgNumber / dbgCode / dbgWriteIn  in  1 / 12 / CSR_Code / 32  debug access fields
- dbgGnt  out  1  debug access performed this cycle
- dbgRespValid  out  1  dbgReadOut valid
- dbgRespReady  in  1  debug side accepts response
- dbgReadOut  out  32  registered debug read data
- triggerExcpt, triggerInterrupt  in  1 each  trap/interrupt being taken this cycle
- csrWE / csrNumber / csrCode / csrWriteIn  out  1 / 12 / CSR_Code / 32  to CSR unit
- csrReadOut  in  32  from CSR unit

## Operation
- FSM states: IDLE, RESP.
- IDLE, grant condition: grant = dbgReq && !triggerExcpt && !triggerInterrupt && (!pipeReq || forced), where forced = (starveCnt == STARVE_LIMIT).
- On grant:
  - dbgGnt=1 and CSR outputs carry the dbg fields.
  - csrReadOut is latched into dbgReadOut.
  - Next state RESP; starveCnt cleared.
  - If pipeReq is also high (forced grant): pipeStall=1 and the pipeline access is not issued.
- No grant: CSR outputs carry the pipe fields; csrWE = pipeReq && pipeWE; pipeReadOut = csrReadOut.
- starveCnt increments (saturating at STARVE_LIMIT) in each IDLE cycle with dbgReq high and no grant.
- RESP: dbgRespValid=1. No debug grant is issued; the pipeline has the port unconditionally. Return to IDLE when dbgRespReady=1.
- starveCnt is held in RESP.
- Trap/interrupt cycle: a debug grant is never issued, including a forced one, and pipeStall=0. starveCnt still increments if pipeReq is high.
- pipeReadOut always mirrors csrReadOut; its value is meaningful only when the pipeline owns the port.

## Timing
- Reset values: state IDLE, starveCnt 0, dbgGnt 0, dbgRespValid 0, dbgReadOut 0, pipeStall 0, csrWE 0.
- Pipeline access: zero-cycle pass-through.
- Debug latency: grant cycle T, then dbgRespValid from T+1 until the handshake completes. The earliest next grant is the cycle after the dbgRespReady cycle.
- Debug write takes effect at the clock edge ending cycle T.
- dbgGnt, pipeStall and the CSR outputs are combinational from the current inputs and state; dbgRespValid and dbgReadOut are registered.
- Reset asserted mid-response drops dbgRespValid immediately (asynchronous); the debug side must reissue the request.

## Configuration
- CSR_PORT_ARBITER_STARVATION_GUARD_EN defined: forced grant and starveCnt as above.
- Not defined: strict pipeline priority, forced is constant 0, pipeStall tied 0, no counter flops. A debug request waits indefinitely while pipeReq stays high.

## Structure
- Shared package CSR_PortArbiterTypes:
  - CSR_PortArbState enum {IDLE, RESP}
  - CSR_ArbStarveCountPath, 4-bit
  - constant CSR_ARB_STARVE_LIMIT_MAX = 15
- CSR_NumberPath, DataPath and CSR_Code come from the existing CSR unit types.
- One sub-module, csr_arb_starve_counter: saturating counter with inc/clear/hold inputs and an atLimit output. Instantiated only when the macro is defined.

## Test plan
- Reset, then dbgReq=1 with pipeReq=0 and dbgNumber=0x340, dbgWE=1, dbgWriteIn=0xA5A5: dbgGnt=1 in the same cycle, csrWE=1, mscratch=0xA5A5. dbgRespValid=1 the next cycle.
- pipeReq=1 continuously and dbgReq=1, STARVE_LIMIT=4: 4 refused cycles, then dbgGnt=1 and pipeStall=1 in cycle 5. With the macro undefined, dbgGnt stays 0 for 20 cycles.
- Forced-grant cycle coinciding with triggerExcpt=1: dbgGnt=0 and pipeStall=0. Grant occurs in the first cycle with triggerExcpt=0.
- Debug read of 0x300 returning 0x1888 with dbgRespReady=0 for 3 cycles: dbgRespValid and dbgReadOut=0x1888 stay stable. Pipeline accesses proceed meanwhile and no second debug grant is issued.
- Assert rst while in RESP: dbgRespValid=0 and dbgReadOut=0 immediately; state is IDLE after release.
